// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: hazard FSM state encoding and register-number width.
package pipeline_pkg;

    localparam int unsigned RegW = 5;
    localparam logic [RegW-1:0] RegZero = '0;

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StStall = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

endpackage

// File: rtl/hazard_match.sv
// Destination-vs-source register comparator; $0 never produces a dependency.
module hazard_match
    import pipeline_pkg::*;
(
    input  logic [RegW-1:0] dest_i,
    input  logic            valid_i,
    input  logic [RegW-1:0] rs_i,
    input  logic [RegW-1:0] rt_i,
    input  logic            use_rt_i,
    output logic            match_o
);

    assign match_o = valid_i && (dest_i != RegZero) &&
                     ((dest_i == rs_i) || (use_rt_i && (dest_i == rt_i)));

endmodule

// File: rtl/hazard_detection.sv
// Stall/flush/freeze controller for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall/flush/wait event counters.
module hazard_detection
    import pipeline_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [RegW-1:0] IF_ID_RS_i,
    input  logic [RegW-1:0] IF_ID_RT_i,
    input  logic            IF_ID_use_rt_i,
    input  logic            IF_ID_branch_i,
    input  logic            branch_taken_i,
    input  logic [RegW-1:0] ID_EX_WR_i,
    input  logic            ID_EX_regwrite_i,
    input  logic            ID_EX_memread_i,
    input  logic [RegW-1:0] EX_MEM_WR_i,
    input  logic            EX_MEM_memread_i,
    input  logic            EX_MEM_memop_i,
    input  logic            dmem_ready_i,
    output logic            PC_write_o,
    output logic            IF_ID_write_o,
    output logic            IF_ID_flush_o,
    output logic            ID_EX_write_o,
    output logic            ID_EX_bubble_o,
    output logic            EX_MEM_write_o,
    output logic            MEM_WB_bubble_o,
`ifdef HAZARD_STATS_EN
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o,
    output logic [31:0]     wait_cnt_o,
`endif
    output logic            timeout_o
);

    localparam int unsigned WcW = $clog2(WAIT_MAX + 1);
    localparam logic [WcW-1:0] WaitMax = WcW'(WAIT_MAX);

    logic ld_match, alu_match, memld_match;
    logic freeze, load_use, branch_data, hold, flush;
    logic [1:0] state_q, state_d;
    logic [WcW-1:0] wait_cnt_q, wait_cnt_d;
    logic timeout_q, timeout_d;

    hazard_match u_match_ex_load (
        .dest_i   (ID_EX_WR_i),
        .valid_i  (ID_EX_memread_i),
        .rs_i     (IF_ID_RS_i),
        .rt_i     (IF_ID_RT_i),
        .use_rt_i (IF_ID_use_rt_i),
        .match_o  (ld_match)
    );

    hazard_match u_match_ex_alu (
        .dest_i   (ID_EX_WR_i),
        .valid_i  (ID_EX_regwrite_i),
        .rs_i     (IF_ID_RS_i),
        .rt_i     (IF_ID_RT_i),
        .use_rt_i (IF_ID_use_rt_i),
        .match_o  (alu_match)
    );

    hazard_match u_match_mem_load (
        .dest_i   (EX_MEM_WR_i),
        .valid_i  (EX_MEM_memread_i),
        .rs_i     (IF_ID_RS_i),
        .rt_i     (IF_ID_RT_i),
        .use_rt_i (IF_ID_use_rt_i),
        .match_o  (memld_match)
    );

    assign freeze      = EX_MEM_memop_i && !dmem_ready_i;
    assign load_use    = ld_match;
    assign branch_data = IF_ID_branch_i && (alu_match || memld_match);
    // Lower-priority hazards are masked by the ones above them.
    assign hold        = !freeze && (load_use || branch_data);
    assign flush       = !freeze && !hold && IF_ID_branch_i && branch_taken_i;

    // Mealy control outputs in priority order; reset parks the pipeline.
    always_comb begin
        PC_write_o      = 1'b1;
        IF_ID_write_o   = 1'b1;
        IF_ID_flush_o   = 1'b0;
        ID_EX_write_o   = 1'b1;
        ID_EX_bubble_o  = 1'b0;
        EX_MEM_write_o  = 1'b1;
        MEM_WB_bubble_o = 1'b0;
        if (!rst_i) begin
            PC_write_o      = 1'b0;
            IF_ID_write_o   = 1'b0;
            IF_ID_flush_o   = 1'b1;
            ID_EX_write_o   = 1'b0;
            ID_EX_bubble_o  = 1'b1;
            EX_MEM_write_o  = 1'b0;
            MEM_WB_bubble_o = 1'b1;
        end else if (freeze) begin
            PC_write_o      = 1'b0;
            IF_ID_write_o   = 1'b0;
            ID_EX_write_o   = 1'b0;
            EX_MEM_write_o  = 1'b0;
            MEM_WB_bubble_o = 1'b1;
        end else if (hold) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_bubble_o = 1'b1;
        end else if (flush) begin
            IF_ID_flush_o = 1'b1;
        end
    end

    // Next state plus wait counter: the counter holds the length of the current freeze run.
    always_comb begin
        state_d    = freeze ? StWait : (hold ? StStall : StRun);
        wait_cnt_d = '0;
        if (state_d == StWait) begin
            if (state_q != StWait) begin
                wait_cnt_d = WcW'(1);
            end else if (wait_cnt_q < WaitMax) begin
                wait_cnt_d = wait_cnt_q + WcW'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end
        timeout_d = timeout_q || (wait_cnt_d == WaitMax);
    end

    // State, watchdog counter and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_evt_q;

    // Saturating event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_evt_q  <= '0;
        end else begin
            if (state_d == StStall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && flush_cnt_q != '1)              flush_cnt_q <= flush_cnt_q + 32'd1;
            if (state_d == StWait && wait_evt_q != '1)   wait_evt_q  <= wait_evt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign wait_cnt_o  = wait_evt_q;
`endif

endmodule

// File: tb/tb_hazard_detection.sv
// Self-checking bench for hazard_detection (WAIT_MAX overridden to 4).
module tb_hazard_detection;

    localparam int unsigned WMax = 4;
    // Output bundle order: {PC, IF_ID_w, IF_ID_flush, ID_EX_w, ID_EX_bubble, EX_MEM_w, MEM_WB_bubble}
    localparam logic [6:0] RunV    = 7'b1101010;
    localparam logic [6:0] StallV  = 7'b0001110;
    localparam logic [6:0] FlushV  = 7'b1111010;
    localparam logic [6:0] FreezeV = 7'b0000001;
    localparam logic [6:0] ResetV  = 7'b0010101;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_wr, mem_wr;
    logic id_use_rt, id_branch, taken, ex_regwrite, ex_memread, mem_memread, mem_memop, dmem_ready;
    logic pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, memwb_bub, timeout;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif
    logic [6:0] outs;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int unsigned m_run;
    bit          m_tmo;
    int unsigned m_stall, m_flush, m_wait;

    always #5 clk = ~clk;

    assign outs = {pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, memwb_bub};

    hazard_detection #(.WAIT_MAX(WMax)) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .IF_ID_RS_i       (id_rs),
        .IF_ID_RT_i       (id_rt),
        .IF_ID_use_rt_i   (id_use_rt),
        .IF_ID_branch_i   (id_branch),
        .branch_taken_i   (taken),
        .ID_EX_WR_i       (ex_wr),
        .ID_EX_regwrite_i (ex_regwrite),
        .ID_EX_memread_i  (ex_memread),
        .EX_MEM_WR_i      (mem_wr),
        .EX_MEM_memread_i (mem_memread),
        .EX_MEM_memop_i   (mem_memop),
        .dmem_ready_i     (dmem_ready),
        .PC_write_o       (pc_w),
        .IF_ID_write_o    (ifid_w),
        .IF_ID_flush_o    (ifid_flush),
        .ID_EX_write_o    (idex_w),
        .ID_EX_bubble_o   (idex_bub),
        .EX_MEM_write_o   (exmem_w),
        .MEM_WB_bubble_o  (memwb_bub),
`ifdef HAZARD_STATS_EN
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt),
        .wait_cnt_o       (wait_cnt),
`endif
        .timeout_o        (timeout)
    );

    function automatic bit depends(input logic [4:0] dest, input logic valid);
        if (!valid || dest == 5'd0) return 1'b0;
        return (dest == id_rs) || (id_use_rt && dest == id_rt);
    endfunction

    // 0 run, 1 flush, 2 stall, 3 freeze
    function automatic int classify();
        if (mem_memop && !dmem_ready) return 3;
        if (depends(ex_wr, ex_memread)) return 2;
        if (id_branch && (depends(ex_wr, ex_regwrite) || depends(mem_wr, mem_memread))) return 2;
        if (id_branch && taken) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] exp_out();
        if (!rst_n) return ResetV;
        case (classify())
            3:       return FreezeV;
            2:       return StallV;
            1:       return FlushV;
            default: return RunV;
        endcase
    endfunction

    task automatic model_clear();
        m_run = 0; m_tmo = 0; m_stall = 0; m_flush = 0; m_wait = 0;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_wr = 0; mem_wr = 0;
        id_use_rt = 0; id_branch = 0; taken = 0; ex_regwrite = 0; ex_memread = 0;
        mem_memread = 0; mem_memop = 0; dmem_ready = 1;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int c;
        c = classify();
        if (rst_n) begin
            if (c == 3) begin
                if (m_run < WMax) m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run == WMax) m_tmo = 1;
            if (c == 2) m_stall++;
            if (c == 1) m_flush++;
            if (c == 3) m_wait++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_clear();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_clear();
        ex_memread = 1; ex_wr = 7; id_rs = 7;
        #1;
        vectors++;
        if (outs !== ResetV) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", outs, ResetV);
        end
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_timeout: got %b expected 0", timeout);
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        if ({stall_cnt, flush_cnt, wait_cnt} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, wait_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_wr = 2; id_rs = 2;
        #1;
        vectors++;
        if (outs !== StallV) begin
            miscompares++;
            $display("FAIL load_use_stall: got %b expected %b", outs, StallV);
        end
        tick();
        clear_inputs();
        id_rs = 2;
        #1;
        vectors++;
        if (outs !== RunV) begin
            miscompares++;
            $display("FAIL load_use_resume: got %b expected %b", outs, RunV);
        end
        tick();
        // rt dependency only counts when rt is a source
        clear_inputs();
        ex_memread = 1; ex_wr = 9; id_rt = 9; id_rs = 1;
        #1;
        vectors++;
        if (outs !== RunV) begin
            miscompares++;
            $display("FAIL load_use_rt_unused: got %b expected %b", outs, RunV);
        end
        id_use_rt = 1;
        #1;
        vectors++;
        if (outs !== StallV) begin
            miscompares++;
            $display("FAIL load_use_rt_used: got %b expected %b", outs, StallV);
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        id_branch = 1; taken = 1; id_rs = 3; ex_regwrite = 1; ex_wr = 3;
        #1;
        vectors++;
        if (outs !== StallV) begin
            miscompares++;
            $display("FAIL branch_alu_dep: got %b expected %b", outs, StallV);
        end
        tick();
        clear_inputs();
        id_branch = 1; taken = 1; id_rs = 3;
        #1;
        vectors++;
        if (outs !== FlushV) begin
            miscompares++;
            $display("FAIL branch_taken_flush: got %b expected %b", outs, FlushV);
        end
        tick();
        taken = 0;
        #1;
        vectors++;
        if (outs !== RunV) begin
            miscompares++;
            $display("FAIL branch_not_taken: got %b expected %b", outs, RunV);
        end
        tick();
    endtask

    task automatic test_load_branch();
        int bubbles = 0;
        clear_inputs();
        id_branch = 1; taken = 1; id_rs = 4;
        ex_memread = 1; ex_regwrite = 1; ex_wr = 4;
        #1;
        vectors++;
        if (outs !== StallV) begin
            miscompares++;
            $display("FAIL load_branch_first: got %b expected %b", outs, StallV);
        end
        if (idex_bub) bubbles++;
        tick();
        ex_memread = 0; ex_regwrite = 0; ex_wr = 0;
        mem_memread = 1; mem_memop = 1; mem_wr = 4;
        #1;
        vectors++;
        if (outs !== StallV) begin
            miscompares++;
            $display("FAIL load_branch_second: got %b expected %b", outs, StallV);
        end
        if (idex_bub) bubbles++;
        tick();
        mem_memread = 0; mem_memop = 0; mem_wr = 0;
        #1;
        vectors++;
        if (outs !== FlushV) begin
            miscompares++;
            $display("FAIL load_branch_flush: got %b expected %b", outs, FlushV);
        end
        if (idex_bub) bubbles++;
        vectors++;
        if (bubbles !== 2) begin
            miscompares++;
            $display("FAIL load_branch_bubbles: got %0d expected 2", bubbles);
        end
        tick();
    endtask

    task automatic test_dest_zero();
        clear_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_wr = 0; id_rs = 0;
        id_branch = 1; mem_memread = 1; mem_wr = 0;
        #1;
        vectors++;
        if (outs !== RunV) begin
            miscompares++;
            $display("FAIL dest_zero: got %b expected %b", outs, RunV);
        end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        clear_inputs();
        mem_memop = 1; dmem_ready = 0;
        ex_memread = 1; ex_wr = 5; id_rs = 5;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (outs !== FreezeV) begin
                miscompares++;
                $display("FAIL freeze_cycle%0d: got %b expected %b", i, outs, FreezeV);
            end
            tick();
        end
        dmem_ready = 1;
        #1;
        vectors++;
        if (outs !== StallV) begin
            miscompares++;
            $display("FAIL freeze_then_load_use: got %b expected %b", outs, StallV);
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        if (wait_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL freeze_wait_cnt: got %0d expected 3", wait_cnt);
        end
`endif
        tick();
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_no_timeout: got %b expected 0", timeout);
        end
        // Ready in the same cycle as the access: no freeze
        clear_inputs();
        mem_memop = 1; dmem_ready = 1;
        #1;
        vectors++;
        if (outs !== RunV) begin
            miscompares++;
            $display("FAIL ready_same_cycle: got %b expected %b", outs, RunV);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        clear_inputs();
        mem_memop = 1; dmem_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            vectors++;
            if (timeout !== (i >= int'(WMax))) begin
                miscompares++;
                $display("FAIL timeout_after_%0d: got %b expected %b", i, timeout, i >= int'(WMax));
            end
        end
        dmem_ready = 1;
        tick();
        vectors++;
        if (timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout);
        end
        dmem_ready = 0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (timeout !== 1'b0 || outs !== ResetV) begin
            miscompares++;
            $display("FAIL timeout_async_reset: got tmo=%b outs=%b expected tmo=0 outs=%b",
                     timeout, outs, ResetV);
        end
        model_clear();
        rst_n = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        model_clear();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_wr       = 5'($urandom_range(0, 3));
            mem_wr      = 5'($urandom_range(0, 3));
            id_use_rt   = 1'($urandom_range(0, 1));
            id_branch   = 1'($urandom_range(0, 1));
            taken       = 1'($urandom_range(0, 1));
            ex_regwrite = 1'($urandom_range(0, 1));
            ex_memread  = ($urandom_range(0, 2) == 0);
            mem_memread = 1'($urandom_range(0, 1));
            mem_memop   = ($urandom_range(0, 2) == 0);
            dmem_ready  = ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (outs !== exp_out()) begin
                miscompares++;
                $display("FAIL random_outs[%0d]: got %b expected %b", n, outs, exp_out());
            end
            tick();
            vectors++;
            if (timeout !== m_tmo) begin
                miscompares++;
                $display("FAIL random_timeout[%0d]: got %b expected %b", n, timeout, m_tmo);
            end
`ifdef HAZARD_STATS_EN
            vectors++;
            if (stall_cnt !== m_stall || flush_cnt !== m_flush || wait_cnt !== m_wait) begin
                miscompares++;
                $display("FAIL random_stats[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         n, stall_cnt, flush_cnt, wait_cnt, m_stall, m_flush, m_wait);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_load_branch();
        test_dest_zero();
        test_freeze();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
